// File: rtl/julia_result_arbiter.sv
// julia_result_arbiter: round-robin collector from NUM_JULIA Julia workers into a tagged result FIFO.
// Define JULIA_ARB_STATS_EN to build the grant / full-stall counters (tied to 0 otherwise).
module julia_result_arbiter #(
    parameter int unsigned NUM_JULIA  = 8,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned SRC_W     = (NUM_JULIA > 1) ? $clog2(NUM_JULIA) : 1
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic [NUM_JULIA*ADDR_W-1:0] cataddresses,
    input  logic [NUM_JULIA*PIX_W-1:0]  catpixels,
    input  logic [NUM_JULIA-1:0]        done,
    output logic [NUM_JULIA-1:0]        ack,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ADDR_W-1:0]           out_addr,
    output logic [PIX_W-1:0]            out_pixel,
    output logic [SRC_W-1:0]            out_src,
    output logic [31:0]                 grant_count,
    output logic [31:0]                 full_stall_count
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [SRC_W:0] NUM_JULIA_W = (SRC_W + 1)'(NUM_JULIA);

    logic [NUM_JULIA-1:0] ack_q, ack_d, req;
    logic [SRC_W-1:0]     ptr_q, ptr_d, grant_idx;
    logic [SRC_W:0]       cand;
    logic                 grant_found, can_push, push, pop, full;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]       count_q;

    logic [ADDR_W-1:0]    addr_mem [FIFO_DEPTH];
    logic [PIX_W-1:0]     pixel_mem [FIFO_DEPTH];
    logic [SRC_W-1:0]     src_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]    last_addr_q;
    logic [PIX_W-1:0]     last_pixel_q;
    logic [SRC_W-1:0]     last_src_q;

    // A worker being acked this cycle still shows done; mask it so it is not granted twice.
    assign req       = done & ~ack_q;
    assign full      = count_q[PTR_W];
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign can_push  = ~full | pop;

    // Rotating priority search starting at ptr_q, wrapping at NUM_JULIA-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < int'(NUM_JULIA); i++) begin
            cand = {1'b0, ptr_q} + (SRC_W + 1)'(i);
            if (cand >= NUM_JULIA_W) begin
                cand = cand - NUM_JULIA_W;
            end
            if (!grant_found && req[cand[SRC_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SRC_W-1:0];
            end
        end
    end

    assign push  = grant_found & can_push;
    assign ack_d = push ? (NUM_JULIA'(1) << grant_idx) : '0;
    assign ptr_d = !push ? ptr_q :
                   (grant_idx == SRC_W'(NUM_JULIA - 1)) ? '0 : grant_idx + SRC_W'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ack_q        <= '0;
            ptr_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_addr_q  <= '0;
            last_pixel_q <= '0;
            last_src_q   <= '0;
        end else begin
            ack_q   <= ack_d;
            ptr_q   <= ptr_d;
            count_q <= count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            // Remember the popped head so the outputs hold it while the FIFO is empty.
            if (pop) begin
                rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
                last_addr_q  <= addr_mem[rd_ptr_q];
                last_pixel_q <= pixel_mem[rd_ptr_q];
                last_src_q   <= src_mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q]  <= cataddresses[grant_idx*ADDR_W +: ADDR_W];
            pixel_mem[wr_ptr_q] <= catpixels[grant_idx*PIX_W +: PIX_W];
            src_mem[wr_ptr_q]   <= grant_idx;
        end
    end

    assign ack       = ack_q;
    assign out_addr  = out_valid ? addr_mem[rd_ptr_q] : last_addr_q;
    assign out_pixel = out_valid ? pixel_mem[rd_ptr_q] : last_pixel_q;
    assign out_src   = out_valid ? src_mem[rd_ptr_q] : last_src_q;

`ifdef JULIA_ARB_STATS_EN
    logic [31:0] grant_count_q, full_stall_count_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            grant_count_q      <= '0;
            full_stall_count_q <= '0;
        end else begin
            if (push) begin
                grant_count_q <= grant_count_q + 32'd1;
            end
            if (|req && !can_push) begin
                full_stall_count_q <= full_stall_count_q + 32'd1;
            end
        end
    end

    assign grant_count      = grant_count_q;
    assign full_stall_count = full_stall_count_q;
`else
    assign grant_count      = '0;
    assign full_stall_count = '0;
`endif

endmodule

// File: tb/tb_julia_result_arbiter.sv
// Directed testbench for julia_result_arbiter (8 workers, depth-4 FIFO).
// Counter checks follow JULIA_ARB_STATS_EN; without it the counters must read 0.
module tb_julia_result_arbiter;
    localparam int NJ = 8;
    localparam int AW = 32;
    localparam int PW = 8;
    localparam int SW = 3;

    logic            clk, n_rst;
    logic [NJ*AW-1:0] cataddresses;
    logic [NJ*PW-1:0] catpixels;
    logic [NJ-1:0]   done, ack, prev_ack;
    logic            out_valid, out_ready;
    logic [AW-1:0]   out_addr;
    logic [PW-1:0]   out_pixel;
    logic [SW-1:0]   out_src;
    logic [31:0]     grant_count, full_stall_count;

    int tests_run = 0;
    int tests_failed = 0;

    julia_result_arbiter #(
        .NUM_JULIA (NJ),
        .ADDR_W    (AW),
        .PIX_W     (PW),
        .FIFO_DEPTH(4)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .cataddresses    (cataddresses),
        .catpixels       (catpixels),
        .done            (done),
        .ack             (ack),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_addr        (out_addr),
        .out_pixel       (out_pixel),
        .out_src         (out_src),
        .grant_count     (grant_count),
        .full_stall_count(full_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Worker model: each worker drops done in the cycle after the one where it saw its ack.
    task automatic step_w();
        @(posedge clk);
        #1;
        done     = done & ~prev_ack;
        prev_ack = ack;
    endtask

    task automatic set_data();
        for (int k = 0; k < NJ; k++) begin
            cataddresses[k*AW +: AW] = 32'h200 + 32'(k * 16);
            catpixels[k*PW +: PW]    = 8'h50 + 8'(k);
        end
    endtask

    task automatic do_reset();
        n_rst     = 1'b0;
        done      = '0;
        out_ready = 1'b0;
        prev_ack  = '0;
        step();
        step();
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (ack !== 8'h00) begin tests_failed++; $display("FAIL rst_ack: got %h want 00", ack); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        tests_run++; if (out_addr !== 32'h0) begin tests_failed++; $display("FAIL rst_addr: got %h want 0", out_addr); end
        tests_run++; if (out_pixel !== 8'h0) begin tests_failed++; $display("FAIL rst_pixel: got %h want 0", out_pixel); end
        tests_run++; if (out_src !== 3'd0) begin tests_failed++; $display("FAIL rst_src: got %0d want 0", out_src); end
        tests_run++; if (grant_count !== 32'd0) begin tests_failed++; $display("FAIL rst_gcnt: got %0d want 0", grant_count); end
        tests_run++; if (full_stall_count !== 32'd0) begin tests_failed++; $display("FAIL rst_scnt: got %0d want 0", full_stall_count); end
    endtask

    task automatic test_single();
        do_reset();
        set_data();
        cataddresses[0 +: AW] = 32'h100;
        catpixels[0 +: PW]    = 8'h7F;
        out_ready = 1'b1;
        done      = 8'h01;
        step();
        tests_run++; if (ack !== 8'h01) begin tests_failed++; $display("FAIL single_ack: got %h want 01", ack); end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b want 1", out_valid); end
        tests_run++; if (out_addr !== 32'h100) begin tests_failed++; $display("FAIL single_addr: got %h want 100", out_addr); end
        tests_run++; if (out_pixel !== 8'h7F) begin tests_failed++; $display("FAIL single_pixel: got %h want 7f", out_pixel); end
        tests_run++; if (out_src !== 3'd0) begin tests_failed++; $display("FAIL single_src: got %0d want 0", out_src); end
        step();
        done = 8'h00;
        tests_run++; if (ack !== 8'h00) begin tests_failed++; $display("FAIL single_noregrant: got %h want 00", ack); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_empty: got %b want 0", out_valid); end
        tests_run++; if (out_addr !== 32'h100) begin tests_failed++; $display("FAIL single_hold_addr: got %h want 100", out_addr); end
        tests_run++; if (out_pixel !== 8'h7F) begin tests_failed++; $display("FAIL single_hold_pixel: got %h want 7f", out_pixel); end
        step();
        tests_run++; if (ack !== 8'h00) begin tests_failed++; $display("FAIL single_idle: got %h want 00", ack); end
    endtask

    task automatic test_round_robin();
        logic [7:0]  exp_ack;
        logic [31:0] exp_addr;
        do_reset();
        set_data();
        out_ready = 1'b1;
        done      = 8'hFF;
        for (int i = 0; i < NJ; i++) begin
            step_w();
            exp_ack  = 8'(1 << i);
            exp_addr = 32'h200 + 32'(i * 16);
            tests_run++; if (ack !== exp_ack) begin tests_failed++; $display("FAIL rr_ack[%0d]: got %h want %h", i, ack, exp_ack); end
            tests_run++; if (out_valid !== 1'b1 || out_src !== 3'(i)) begin tests_failed++; $display("FAIL rr_src[%0d]: got v%b src %0d want v1 src %0d", i, out_valid, out_src, i); end
            tests_run++; if (out_addr !== exp_addr) begin tests_failed++; $display("FAIL rr_addr[%0d]: got %h want %h", i, out_addr, exp_addr); end
        end
        step_w();
        tests_run++; if (ack !== 8'h00) begin tests_failed++; $display("FAIL rr_end_ack: got %h want 00", ack); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_end_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        set_data();
        out_ready = 1'b1;
        done      = 8'h20;
        step();
        tests_run++; if (ack !== 8'h20 || out_src !== 3'd5) begin tests_failed++; $display("FAIL wrap_pre: got ack %h src %0d want 20 src 5", ack, out_src); end
        tests_run++; if (out_addr !== 32'h250) begin tests_failed++; $display("FAIL wrap_pre_addr: got %h want 250", out_addr); end
        step();
        done = 8'h41;
        step();
        tests_run++; if (ack !== 8'h40 || out_src !== 3'd6) begin tests_failed++; $display("FAIL wrap_first: got ack %h src %0d want 40 src 6", ack, out_src); end
        step();
        done = 8'h01;
        tests_run++; if (ack !== 8'h01 || out_src !== 3'd0) begin tests_failed++; $display("FAIL wrap_second: got ack %h src %0d want 01 src 0", ack, out_src); end
        tests_run++; if (out_addr !== 32'h200) begin tests_failed++; $display("FAIL wrap_addr: got %h want 200", out_addr); end
        step();
        done = 8'h00;
        tests_run++; if (ack !== 8'h00) begin tests_failed++; $display("FAIL wrap_end: got %h want 00", ack); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_ack;
        do_reset();
        set_data();
        out_ready = 1'b0;
        done      = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            step_w();
            exp_ack = 8'(1 << i);
            tests_run++; if (ack !== exp_ack) begin tests_failed++; $display("FAIL bp_ack[%0d]: got %h want %h", i, ack, exp_ack); end
            tests_run++; if (out_valid !== 1'b1 || out_src !== 3'd0) begin tests_failed++; $display("FAIL bp_head[%0d]: got v%b src %0d want v1 src 0", i, out_valid, out_src); end
        end
`ifdef JULIA_ARB_STATS_EN
        tests_run++; if (grant_count !== 32'd4) begin tests_failed++; $display("FAIL bp_gcnt_onset: got %0d want 4", grant_count); end
`endif
        step_w();
        tests_run++; if (ack !== 8'h00) begin tests_failed++; $display("FAIL bp_stall_ack: got %h want 00", ack); end
`ifdef JULIA_ARB_STATS_EN
        tests_run++; if (full_stall_count !== 32'd1) begin tests_failed++; $display("FAIL bp_scnt1: got %0d want 1", full_stall_count); end
`endif
        step_w();
        tests_run++; if (ack !== 8'h00 || out_valid !== 1'b1 || out_src !== 3'd0) begin tests_failed++; $display("FAIL bp_hold: got ack %h v%b src %0d want 00 v1 src 0", ack, out_valid, out_src); end
`ifdef JULIA_ARB_STATS_EN
        tests_run++; if (full_stall_count !== 32'd2) begin tests_failed++; $display("FAIL bp_scnt2: got %0d want 2", full_stall_count); end
`endif
        out_ready = 1'b1;
        step_w();
        tests_run++; if (ack !== 8'h10 || out_src !== 3'd1) begin tests_failed++; $display("FAIL bp_popush1: got ack %h src %0d want 10 src 1", ack, out_src); end
        step_w();
        out_ready = 1'b0;
        tests_run++; if (ack !== 8'h20 || out_src !== 3'd2) begin tests_failed++; $display("FAIL bp_popush2: got ack %h src %0d want 20 src 2", ack, out_src); end
        step_w();
        tests_run++; if (ack !== 8'h00 || out_valid !== 1'b1 || out_src !== 3'd2) begin tests_failed++; $display("FAIL bp_still_full: got ack %h v%b src %0d want 00 v1 src 2", ack, out_valid, out_src); end
`ifdef JULIA_ARB_STATS_EN
        tests_run++; if (grant_count !== 32'd6 || full_stall_count !== 32'd3) begin tests_failed++; $display("FAIL bp_cnt_end: got %0d/%0d want 6/3", grant_count, full_stall_count); end
`else
        tests_run++; if (grant_count !== 32'd0 || full_stall_count !== 32'd0) begin tests_failed++; $display("FAIL bp_cnt_tied: got %0d/%0d want 0/0", grant_count, full_stall_count); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_data();
        out_ready = 1'b0;
        done      = 8'h07;
        step_w();
        step_w();
        step_w();
        tests_run++; if (ack !== 8'h04 || done !== 8'h04) begin tests_failed++; $display("FAIL mid_setup: got ack %h done %h want 04 04", ack, done); end
        n_rst = 1'b0;
        #1;
        tests_run++; if (out_valid !== 1'b0 || ack !== 8'h00) begin tests_failed++; $display("FAIL mid_rst: got v%b ack %h want v0 00", out_valid, ack); end
        tests_run++; if (out_src !== 3'd0 || out_addr !== 32'h0) begin tests_failed++; $display("FAIL mid_rst_head: got src %0d addr %h want 0 0", out_src, out_addr); end
        step();
        n_rst    = 1'b1;
        prev_ack = '0;
        step();
        tests_run++; if (ack !== 8'h04 || out_valid !== 1'b1 || out_src !== 3'd2) begin tests_failed++; $display("FAIL mid_reserve: got ack %h v%b src %0d want 04 v1 src 2", ack, out_valid, out_src); end
        tests_run++; if (out_addr !== 32'h220 || out_pixel !== 8'h52) begin tests_failed++; $display("FAIL mid_data: got %h/%h want 220/52", out_addr, out_pixel); end
`ifdef JULIA_ARB_STATS_EN
        tests_run++; if (grant_count !== 32'd1) begin tests_failed++; $display("FAIL mid_gcnt: got %0d want 1", grant_count); end
`endif
    endtask

    initial begin
        n_rst        = 1'b0;
        done         = '0;
        out_ready    = 1'b0;
        prev_ack     = '0;
        cataddresses = '0;
        catpixels    = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
